// File: rtl/mips_pkg.sv
// Shared MIPS32 definitions for the memory stage: opcodes,
// access sizes, memory-stage FSM states and a size decoder.
package mips_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_e;

  typedef enum logic {
    IDLE,
    WAIT
  } state_e;

  // Unknown opcodes that still touch memory fall back to word size.
  function automatic size_e size_of(input logic [5:0] op);
    size_e s;
    s = SZ_W;
    unique case (op)
      OP_LB, OP_LBU, OP_SB: s = SZ_B;
      OP_LH, OP_LHU, OP_SH: s = SZ_H;
      default:              s = SZ_W;
    endcase
    return s;
  endfunction

  function automatic logic is_unsigned(input logic [5:0] op);
    return (op == OP_LBU) || (op == OP_LHU);
  endfunction

endpackage

// File: rtl/mem_access_stage_align.sv
// Lane steering for loads/stores: byte enables, replicated
// store data and the extracted, extended load value.
module load_store_align
  import mips_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  off,
  input  logic        load_uns,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [31:0] lane;

  assign lane = rdata >> {off, 3'b000};

  always_comb begin
    be        = 4'b1111;
    wdata     = store_data;
    load_data = rdata;
    unique case (size)
      SZ_B: begin
        be        = 4'b0001 << off;
        wdata     = {4{store_data[7:0]}};
        load_data = load_uns ? {24'b0, lane[7:0]}
                             : {{24{lane[7]}}, lane[7:0]};
      end
      SZ_H: begin
        be        = 4'b0011 << off;
        wdata     = {2{store_data[15:0]}};
        load_data = load_uns ? {16'b0, lane[15:0]}
                             : {{16{lane[15]}}, lane[15:0]};
      end
      SZ_W: begin
        be        = 4'b1111;
        wdata     = store_data;
        load_data = rdata;
      end
      default: begin
        be        = 4'b1111;
        wdata     = store_data;
        load_data = rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MIPS32 memory stage: req/ack data-memory access with stall,
// timeout abort, misalign detection and MEM/WB registers.
module mem_access_stage
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] iPC,
  input  logic [31:0] iIR,
  input  logic [31:0] ialu_res,
  input  logic [31:0] iData_forMem,
  input  logic [4:0]  iwrite_addr,
  input  logic        imem_read,
  input  logic        imem_write,
  input  logic        imem_to_reg,
  input  logic        ipc_to_reg,
  input  logic        ireg_write,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall,
  output logic [31:0] oPC,
  output logic [31:0] oIR,
  output logic [4:0]  owrite_addr,
  output logic        oreg_write,
  output logic [31:0] owb_data,
  output logic        omisalign,
  output logic        obus_err
);

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  size_e            size;
  logic [1:0]       off;
  logic             mem_op, aligned, access;
  logic             misalign, abort;
  logic [31:0]      load_data, wb_sel;

  assign size     = size_of(iIR[31:26]);
  assign off      = ialu_res[1:0];
  assign mem_op   = imem_read | imem_write;
  assign aligned  = (size == SZ_B) ||
                    (size == SZ_H && !off[0]) ||
                    (off == 2'b00);
  assign access   = mem_op & aligned;
  assign misalign = reset & (state == IDLE) & mem_op & ~aligned;

  assign dmem_we   = imem_write;
  assign dmem_addr = {ialu_res[31:2], 2'b00};

  load_store_align u_align (
    .size       (size),
    .off        (off),
    .load_uns   (is_unsigned(iIR[31:26])),
    .store_data (iData_forMem),
    .rdata      (dmem_rdata),
    .be         (dmem_be),
    .wdata      (dmem_wdata),
    .load_data  (load_data)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dmem_req  = 1'b0;
    stall     = 1'b0;
    abort     = 1'b0;
    unique case (state)
      IDLE: begin
        if (access) begin
          dmem_req = 1'b1;
          if (!dmem_ack) begin
            stall     = 1'b1;
            state_nxt = WAIT;
            cnt_nxt   = CNT_W'(1);
          end
        end
      end
      WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ack) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES)) begin
          abort     = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          stall   = 1'b1;
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
    endcase
    // Reset wins over everything, including an access in flight.
    if (!reset) begin
      dmem_req  = 1'b0;
      stall     = 1'b0;
      abort     = 1'b0;
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end
  end

  always_comb begin
    wb_sel = ialu_res;
    if (ipc_to_reg)       wb_sel = iPC + 32'd4;
    else if (imem_to_reg) wb_sel = load_data;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      oPC         <= '0;
      oIR         <= '0;
      owrite_addr <= '0;
      oreg_write  <= 1'b0;
      owb_data    <= '0;
      omisalign   <= 1'b0;
      obus_err    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      omisalign <= misalign;
      obus_err  <= abort;
      if (stall) begin
        oreg_write <= 1'b0;
        oIR        <= '0;
      end else begin
        oPC         <= iPC;
        oIR         <= iIR;
        owrite_addr <= iwrite_addr;
        oreg_write  <= ireg_write & ~misalign & ~abort;
        if (!abort) owb_data <= wb_sel;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage with a
// scoreboard queue of expected MEM/WB results.
module tb_mem_access_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] iPC, iIR, ialu_res, iData_forMem;
  logic [4:0]  iwrite_addr;
  logic        imem_read, imem_write, imem_to_reg;
  logic        ipc_to_reg, ireg_write;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        stall;
  logic [31:0] oPC, oIR, owb_data;
  logic [4:0]  owrite_addr;
  logic        oreg_write, omisalign, obus_err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] wb;
    logic [4:0]  wa;
    logic        wr;
    logic        wb_care;
    logic        mis;
    logic        berr;
  } exp_t;

  exp_t sb[$];

  mem_access_stage #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clock        (clock),
    .reset        (reset),
    .iPC          (iPC),
    .iIR          (iIR),
    .ialu_res     (ialu_res),
    .iData_forMem (iData_forMem),
    .iwrite_addr  (iwrite_addr),
    .imem_read    (imem_read),
    .imem_write   (imem_write),
    .imem_to_reg  (imem_to_reg),
    .ipc_to_reg   (ipc_to_reg),
    .ireg_write   (ireg_write),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_be      (dmem_be),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_ack     (dmem_ack),
    .stall        (stall),
    .oPC          (oPC),
    .oIR          (oIR),
    .owrite_addr  (owrite_addr),
    .oreg_write   (oreg_write),
    .owb_data     (owb_data),
    .omisalign    (omisalign),
    .obus_err     (obus_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic [5:0] op,
                       input logic [31:0] alu, input logic [31:0] sd,
                       input logic [4:0] wa, input logic rd,
                       input logic wr, input logic m2r,
                       input logic p2r, input logic rw);
    iPC          = pc;
    iIR          = {op, 26'h0000abc};
    ialu_res     = alu;
    iData_forMem = sd;
    iwrite_addr  = wa;
    imem_read    = rd;
    imem_write   = wr;
    imem_to_reg  = m2r;
    ipc_to_reg   = p2r;
    ireg_write   = rw;
    #1;
  endtask

  task automatic nop();
    drive(32'h0, 6'h00, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 0);
  endtask

  task automatic push(input string tag, input logic wr,
                      input logic [31:0] wb, input logic care,
                      input logic mis, input logic berr);
    exp_t e;
    e.tag     = tag;
    e.pc      = iPC;
    e.ir      = iIR;
    e.wa      = iwrite_addr;
    e.wr      = wr;
    e.wb      = wb;
    e.wb_care = care;
    e.mis     = mis;
    e.berr    = berr;
    sb.push_back(e);
  endtask

  task automatic tick_check();
    exp_t e;
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL sb_empty: observed 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_wr"}, 32'(oreg_write), 32'(e.wr));
      chk({e.tag, "_pc"}, oPC, e.pc);
      chk({e.tag, "_ir"}, oIR, e.ir);
      chk({e.tag, "_wa"}, 32'(owrite_addr), 32'(e.wa));
      chk({e.tag, "_mis"}, 32'(omisalign), 32'(e.mis));
      chk({e.tag, "_berr"}, 32'(obus_err), 32'(e.berr));
      if (e.wb_care) chk({e.tag, "_wb"}, owb_data, e.wb);
    end
  endtask

  initial begin
    int n;
    reset      = 1'b0;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    nop();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_wr", 32'(oreg_write), 32'd0);
    chk("rst_wb", owb_data, 32'd0);
    chk("rst_pc", oPC, 32'd0);
    chk("rst_ir", oIR, 32'd0);
    reset = 1'b1;

    // LW, ack in the same cycle
    drive(32'h1000, 6'h23, 32'h100, 32'h0, 5'd8, 1, 0, 1, 0, 1);
    dmem_rdata = 32'hDEADBEEF;
    dmem_ack   = 1'b1;
    #1;
    chk("lw_req", 32'(dmem_req), 32'd1);
    chk("lw_stall", 32'(stall), 32'd0);
    chk("lw_addr", dmem_addr, 32'h100);
    chk("lw_be", 32'(dmem_be), 32'hF);
    push("lw", 1, 32'hDEADBEEF, 1, 0, 0);
    tick_check();

    // LB / LBU from the top byte lane
    dmem_rdata = 32'h80FF7F01;
    drive(32'h1004, 6'h20, 32'h103, 32'h0, 5'd9, 1, 0, 1, 0, 1);
    chk("lb_be", 32'(dmem_be), 32'h8);
    chk("lb_addr", dmem_addr, 32'h100);
    push("lb", 1, 32'hFFFFFF80, 1, 0, 0);
    tick_check();
    drive(32'h1008, 6'h24, 32'h103, 32'h0, 5'd9, 1, 0, 1, 0, 1);
    push("lbu", 1, 32'h00000080, 1, 0, 0);
    tick_check();

    // LH / LHU from the upper half
    drive(32'h100C, 6'h21, 32'h102, 32'h0, 5'd10, 1, 0, 1, 0, 1);
    chk("lh_be", 32'(dmem_be), 32'hC);
    push("lh", 1, 32'hFFFF80FF, 1, 0, 0);
    tick_check();
    drive(32'h1010, 6'h25, 32'h102, 32'h0, 5'd10, 1, 0, 1, 0, 1);
    push("lhu", 1, 32'h000080FF, 1, 0, 0);
    tick_check();

    // SH with ack after three stalled cycles
    dmem_ack = 1'b0;
    drive(32'h1014, 6'h29, 32'h202, 32'h0000ABCD, 5'd0, 0, 1, 0, 0, 0);
    chk("sh_be", 32'(dmem_be), 32'hC);
    chk("sh_wdata", dmem_wdata, 32'hABCDABCD);
    chk("sh_we", 32'(dmem_we), 32'd1);
    push("sh", 0, 32'h202, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("sh_stall%0d", i), 32'(stall), 32'd1);
      chk($sformatf("sh_req%0d", i), 32'(dmem_req), 32'd1);
      @(posedge clock);
      #1;
      chk($sformatf("sh_bub_wr%0d", i), 32'(oreg_write), 32'd0);
      chk($sformatf("sh_bub_ir%0d", i), oIR, 32'd0);
    end
    dmem_ack = 1'b1;
    #1;
    chk("sh_stall_end", 32'(stall), 32'd0);
    tick_check();
    dmem_ack = 1'b0;

    // SB and SW store lanes
    dmem_ack = 1'b1;
    drive(32'h1018, 6'h28, 32'h201, 32'h1234565A, 5'd0, 0, 1, 0, 0, 0);
    chk("sb_be", 32'(dmem_be), 32'h2);
    chk("sb_wdata", dmem_wdata, 32'h5A5A5A5A);
    push("sb", 0, 32'h201, 1, 0, 0);
    tick_check();
    drive(32'h101C, 6'h2B, 32'h204, 32'hCAFEF00D, 5'd0, 0, 1, 0, 0, 0);
    chk("sw_be", 32'(dmem_be), 32'hF);
    chk("sw_wdata", dmem_wdata, 32'hCAFEF00D);
    push("sw", 0, 32'h204, 1, 0, 0);
    tick_check();
    dmem_ack = 1'b0;

    // misaligned LW
    drive(32'h1020, 6'h23, 32'h101, 32'h0, 5'd11, 1, 0, 1, 0, 1);
    chk("mis_req", 32'(dmem_req), 32'd0);
    chk("mis_stall", 32'(stall), 32'd0);
    push("mis", 0, 32'h0, 0, 1, 0);
    tick_check();
    nop();
    push("mis_after", 0, 32'h0, 1, 0, 0);
    tick_check();

    // LW that never gets acknowledged
    drive(32'h1024, 6'h23, 32'h300, 32'h0, 5'd12, 1, 0, 1, 0, 1);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!stall) break;
      n++;
      @(posedge clock);
      #1;
    end
    chk("to_stall_cycles", 32'(n), 32'd16);
    push("to", 0, 32'h0, 0, 0, 1);
    tick_check();
    nop();
    push("to_after", 0, 32'h0, 1, 0, 0);
    tick_check();

    // JAL and plain ALU result
    drive(32'h00400010, 6'h03, 32'h0, 32'h0, 5'd31, 0, 0, 0, 1, 1);
    push("jal", 1, 32'h00400014, 1, 0, 0);
    tick_check();
    drive(32'h1028, 6'h00, 32'h12345678, 32'h0, 5'd3, 0, 0, 0, 0, 1);
    push("alu", 1, 32'h12345678, 1, 0, 0);
    tick_check();

    // reset in the middle of an outstanding access
    drive(32'h102C, 6'h23, 32'h400, 32'h0, 5'd13, 1, 0, 1, 0, 1);
    chk("mr_stall0", 32'(stall), 32'd1);
    @(posedge clock);
    #1;
    chk("mr_stall1", 32'(stall), 32'd1);
    reset = 1'b0;
    #1;
    chk("mr_req", 32'(dmem_req), 32'd0);
    chk("mr_stall", 32'(stall), 32'd0);
    @(posedge clock);
    #1;
    chk("mr_wr", 32'(oreg_write), 32'd0);
    chk("mr_pc", oPC, 32'd0);
    chk("mr_wb", owb_data, 32'd0);
    chk("mr_wa", 32'(owrite_addr), 32'd0);
    reset = 1'b1;
    dmem_rdata = 32'h0BADF00D;
    dmem_ack   = 1'b1;
    drive(32'h1030, 6'h23, 32'h400, 32'h0, 5'd14, 1, 0, 1, 0, 1);
    chk("mr_idle_stall", 32'(stall), 32'd0);
    push("mr_lw", 1, 32'h0BADF00D, 1, 0, 0);
    tick_check();
    dmem_ack = 1'b0;

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
